// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP output stage.
// Contents: neuron count, datapath widths, accumulator/activation types and
// Q8.8 saturation bounds.
package mlp_pkg;

  localparam int unsigned N_NEURONS = 15;
  localparam int unsigned ACC_W     = 32;  // signed Q16.16 MAC sum
  localparam int unsigned DATA_W    = 16;  // signed Q8.8 bias / activation
  localparam int unsigned FRAC_W    = 8;
  localparam int unsigned ADDR_W    = 6;
  // Wide enough that the aligned sum of a full-scale acc and bias cannot overflow.
  localparam int unsigned EXT_W     = 34;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [DATA_W-1:0] act_t;

  localparam act_t SAT_MAX = act_t'(32'sd32767);
  localparam act_t SAT_MIN = act_t'(-32'sd32768);

endpackage

// File: rtl/bias_add_sat.sv
// Combinational bias add, rescale, saturate and optional ReLU.
// Ports:
//   acc_i  - signed Q16.16 MAC sum
//   bias_i - signed Q8.8 bias
//   act_o  - signed Q8.8 activation, saturated (clamped at 0 when Relu=1)
module bias_add_sat
  import mlp_pkg::*;
#(
  parameter bit Relu = 1'b1
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] act_o
);

  localparam logic signed [EXT_W-1:0] ExtMax = EXT_W'(SAT_MAX);
  localparam logic signed [EXT_W-1:0] ExtMin = EXT_W'(SAT_MIN);

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] bias_ext;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] res;
  logic        [DATA_W-1:0] sat;

  always_comb begin
    acc_ext  = {{(EXT_W - ACC_W){acc_i[ACC_W-1]}}, acc_i};
    // Bias is Q8.8; shift it up to line up with the Q16.16 accumulator.
    bias_ext = {{(EXT_W - DATA_W - FRAC_W){bias_i[DATA_W-1]}}, bias_i, {FRAC_W{1'b0}}};
    sum      = acc_ext + bias_ext;
    res      = sum >>> FRAC_W;  // floor back to Q8.8
    if (res > ExtMax) begin
      sat = SAT_MAX;
    end else if (res < ExtMin) begin
      sat = SAT_MIN;
    end else begin
      sat = res[DATA_W-1:0];
    end
    act_o = (Relu && sat[DATA_W-1]) ? '0 : sat;
  end

endmodule

// File: rtl/l2_bias_act.sv
// Layer-2 post-processing: per-neuron bias add + activation, streamed out on a
// valid/ready port, with a once-per-frame argmax report.
// Ports:
//   clk, reset_n                    - clock, async active-low reset
//   acc_valid/acc_ready/acc_data    - incoming MAC sums, neuron order
//   bias_addr/bias_data             - combinational bias register file read
//   out_valid/out_ready/out_data,
//   out_idx/out_last                - activation stream
//   class_valid/class_idx/class_score - one-cycle frame argmax pulse + held result
module l2_bias_act
  import mlp_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ACC_W-1:0]  acc_data,
  output logic [ADDR_W-1:0] bias_addr,
  input  logic [DATA_W-1:0] bias_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              class_valid,
  output logic [ADDR_W-1:0] class_idx,
  output logic [DATA_W-1:0] class_score
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_NEURONS - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] best_idx_q, best_idx_d;
  logic [DATA_W-1:0] best_score_q, best_score_d;
  logic              class_valid_q, class_valid_d;
  logic [ADDR_W-1:0] class_idx_q, class_idx_d;
  logic [DATA_W-1:0] class_score_q, class_score_d;

  logic [DATA_W-1:0] act;
  logic              accept;
  logic              is_last;
  logic              take_new;

  bias_add_sat #(
    .Relu(RELU)
  ) u_bias_add_sat (
    .acc_i (acc_data),
    .bias_i(bias_data),
    .act_o (act)
  );

  always_comb begin
    // Single output register, no skid: accept only if it is empty or draining.
    acc_ready = !out_valid_q || out_ready;
    accept    = acc_valid && acc_ready;
    is_last   = (cnt_q == LastIdx);
    // Strictly greater keeps the lowest index on ties; neuron 0 always seeds.
    take_new  = (cnt_q == '0) || ($signed(act) > $signed(best_score_q));

    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_idx_d     = out_idx_q;
    out_last_d    = out_last_q;
    best_idx_d    = best_idx_q;
    best_score_d  = best_score_q;
    class_valid_d = 1'b0;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = act;
      out_idx_d   = cnt_q;
      out_last_d  = is_last;
      if (take_new) begin
        best_idx_d   = cnt_q;
        best_score_d = act;
      end
      if (is_last) begin
        cnt_d         = '0;
        class_valid_d = 1'b1;
        class_idx_d   = take_new ? cnt_q : best_idx_q;
        class_score_d = take_new ? act : best_score_q;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_idx_q     <= '0;
      out_last_q    <= 1'b0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      class_valid_q <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_idx_q     <= out_idx_d;
      out_last_q    <= out_last_d;
      best_idx_q    <= best_idx_d;
      best_score_q  <= best_score_d;
      class_valid_q <= class_valid_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
    end
  end

  always_comb begin
    bias_addr   = cnt_q;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    out_idx     = out_idx_q;
    out_last    = out_last_q;
    class_valid = class_valid_q;
    class_idx   = class_idx_q;
    class_score = class_score_q;
  end

endmodule

// File: tb/tb_l2_bias_act.sv
// Bench for l2_bias_act: two instances (RELU=0 in slot 0, RELU=1 in slot 1)
// share one stimulus stream; a frame-level model predicts every output.
module tb_l2_bias_act;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        acc_valid;
  logic        out_ready;
  logic [31:0] acc_data;

  logic [1:0]       acc_ready_w, out_valid_w, out_last_w, class_valid_w;
  logic [1:0][5:0]  bias_addr_w, out_idx_w, class_idx_w;
  logic [1:0][15:0] bias_data_w, out_data_w, class_score_w;

  logic [15:0] bias_mem [15];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Bias register file: combinational read.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      bias_data_w[r] = (bias_addr_w[r] < 6'd15) ? bias_mem[bias_addr_w[r][3:0]] : 16'h0000;
    end
  end

  l2_bias_act #(.RELU(1'b0)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready_w[0]),
    .acc_data   (acc_data),
    .bias_addr  (bias_addr_w[0]),
    .bias_data  (bias_data_w[0]),
    .out_valid  (out_valid_w[0]),
    .out_ready  (out_ready),
    .out_data   (out_data_w[0]),
    .out_idx    (out_idx_w[0]),
    .out_last   (out_last_w[0]),
    .class_valid(class_valid_w[0]),
    .class_idx  (class_idx_w[0]),
    .class_score(class_score_w[0])
  );

  l2_bias_act #(.RELU(1'b1)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready_w[1]),
    .acc_data   (acc_data),
    .bias_addr  (bias_addr_w[1]),
    .bias_data  (bias_data_w[1]),
    .out_valid  (out_valid_w[1]),
    .out_ready  (out_ready),
    .out_data   (out_data_w[1]),
    .out_idx    (out_idx_w[1]),
    .out_last   (out_last_w[1]),
    .class_valid(class_valid_w[1]),
    .class_idx  (class_idx_w[1]),
    .class_score(class_score_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain-integer reference for one activation.
  function automatic logic [15:0] act_model(input logic [31:0] acc, input logic [15:0] bias,
                                            input int relu);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(bias)) * 256;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu != 0 && s < 0) s = 0;
    return s[15:0];
  endfunction

  // Model state (slot index = RELU setting).
  int                 m_cnt;
  int                 m_out_idx;
  bit                 m_out_valid;
  bit                 m_out_last;
  bit                 m_class_valid;
  bit                 fired;
  logic        [15:0] m_out_data [2];
  logic        [15:0] m_class_score [2];
  int                 m_class_idx [2];
  logic signed [15:0] m_frame [2][15];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt         = 0;
      m_out_idx     = 0;
      m_out_valid   = 0;
      m_out_last    = 0;
      m_class_valid = 0;
      fired         = 0;
      for (int r = 0; r < 2; r++) begin
        m_out_data[r]    = 16'h0;
        m_class_score[r] = 16'h0;
        m_class_idx[r]   = 0;
      end
    end else begin
      fired         = acc_valid && (!m_out_valid || out_ready);
      m_class_valid = 0;
      if (fired) begin
        for (int r = 0; r < 2; r++) begin
          m_out_data[r]       = act_model(acc_data, bias_mem[m_cnt], r);
          m_frame[r][m_cnt]   = m_out_data[r];
        end
        m_out_idx   = m_cnt;
        m_out_last  = (m_cnt == 14);
        m_out_valid = 1;
        if (m_cnt == 14) begin
          for (int r = 0; r < 2; r++) begin
            int b = 0;
            for (int i = 1; i < 15; i++) if (m_frame[r][i] > m_frame[r][b]) b = i;
            m_class_idx[r]   = b;
            m_class_score[r] = m_frame[r][b];
          end
          m_class_valid = 1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else if (m_out_valid && out_ready) begin
        m_out_valid = 0;
      end
    end
  end

  // Per-cycle comparison, plus DUT-side ordering and drain count.
  int nxt_idx [2];
  int drained [2] = '{0, 0};

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("acc_ready%0d", r), 32'(acc_ready_w[r]), 32'(!m_out_valid || out_ready));
      chk($sformatf("bias_addr%0d", r), 32'(bias_addr_w[r]), 32'(m_cnt));
      chk($sformatf("out_valid%0d", r), 32'(out_valid_w[r]), 32'(m_out_valid));
      chk($sformatf("class_valid%0d", r), 32'(class_valid_w[r]), 32'(m_class_valid));
      chk($sformatf("class_idx%0d", r), 32'(class_idx_w[r]), 32'(m_class_idx[r]));
      chk($sformatf("class_score%0d", r), 32'(class_score_w[r]), 32'(m_class_score[r]));
      if (m_out_valid) begin
        chk($sformatf("out_data%0d", r), 32'(out_data_w[r]), 32'(m_out_data[r]));
        chk($sformatf("out_idx%0d", r), 32'(out_idx_w[r]), 32'(m_out_idx));
        chk($sformatf("out_last%0d", r), 32'(out_last_w[r]), 32'(m_out_last));
      end
      if (!reset_n) begin
        nxt_idx[r] = 0;
      end else if (out_valid_w[r] && out_ready) begin
        chk($sformatf("order%0d", r), 32'(out_idx_w[r]), 32'(nxt_idx[r]));
        nxt_idx[r] = (nxt_idx[r] + 1) % 15;
        drained[r]++;
      end
    end
  end

  // Present one sum and wait (bounded) until it is accepted.
  task automatic send(input logic [31:0] a);
    int t = 0;
    acc_valid = 1'b1;
    acc_data  = a;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!fired && t < 50);
    if (!fired) chk("send_timeout", 32'(t), 32'(0));
  endtask

  int vals_a [15] = '{256, -512, 80, 767, 0, 16, 512, 768, 256, -256, 700, 768, 100, -5, 600};
  int vals_b [15] = '{-100, 50, 400, 900, 10, 20, 30, 40, 50, 60, 70, 80, 90, 899, 5};
  int d0 [2];

  initial begin
    reset_n   = 1'b0;
    acc_valid = 1'b0;
    acc_data  = 32'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) bias_mem[i] = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      chk("rst_acc_ready", 32'(acc_ready_w[r]), 32'd1);
      chk("rst_bias_addr", 32'(bias_addr_w[r]), 32'd0);
      chk("rst_out_valid", 32'(out_valid_w[r]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    bias_mem[0] = 16'h0080;
    bias_mem[1] = 16'h0100;
    bias_mem[2] = 16'h7FFF;
    bias_mem[3] = 16'h8000;

    send(32'h0001_0000);
    for (int r = 0; r < 2; r++) begin
      chk("basic_data", 32'(out_data_w[r]), 32'h0180);
      chk("basic_idx", 32'(out_idx_w[r]), 32'd0);
      chk("basic_addr", 32'(bias_addr_w[r]), 32'd1);
    end

    send(32'hFFFE_0000);
    chk("relu1_data", 32'(out_data_w[1]), 32'h0000);
    chk("relu0_data", 32'(out_data_w[0]), 32'hFF00);

    send(32'h7FFF_FFFF);
    for (int r = 0; r < 2; r++) chk("sat_hi", 32'(out_data_w[r]), 32'h7FFF);

    send(32'h8000_0000);
    chk("sat_lo0", 32'(out_data_w[0]), 32'h8000);
    chk("sat_lo1", 32'(out_data_w[1]), 32'h0000);

    // Reset in the middle of a frame.
    send(32'h0000_1234);
    acc_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    for (int r = 0; r < 2; r++) begin
      chk("mrst_out_valid", 32'(out_valid_w[r]), 32'd0);
      chk("mrst_out_data", 32'(out_data_w[r]), 32'd0);
      chk("mrst_out_idx", 32'(out_idx_w[r]), 32'd0);
      chk("mrst_out_last", 32'(out_last_w[r]), 32'd0);
      chk("mrst_class_valid", 32'(class_valid_w[r]), 32'd0);
      chk("mrst_class_idx", 32'(class_idx_w[r]), 32'd0);
      chk("mrst_class_score", 32'(class_score_w[r]), 32'd0);
      chk("mrst_acc_ready", 32'(acc_ready_w[r]), 32'd1);
      chk("mrst_bias_addr", 32'(bias_addr_w[r]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) bias_mem[i] = 16'h0;

    // Argmax frame: neurons 7 and 11 tie at 0x0300.
    for (int i = 0; i < 15; i++) begin
      send(32'(vals_a[i] * 256));
      if (i == 0) begin
        for (int r = 0; r < 2; r++) chk("post_rst_idx", 32'(out_idx_w[r]), 32'd0);
      end
    end
    acc_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      chk("argmax_pulse", 32'(class_valid_w[r]), 32'd1);
      chk("argmax_idx", 32'(class_idx_w[r]), 32'd7);
      chk("argmax_score", 32'(class_score_w[r]), 32'h0300);
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      chk("argmax_pulse_end", 32'(class_valid_w[r]), 32'd0);
      chk("argmax_idx_hold", 32'(class_idx_w[r]), 32'd7);
    end
    repeat (2) @(posedge clk);
    #1;

    // Backpressure frame: stall 3 cycles after the first accept.
    for (int r = 0; r < 2; r++) d0[r] = drained[r];
    out_ready = 1'b0;
    send(32'(vals_b[0] * 256));
    acc_data = 32'(vals_b[1] * 256);
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        chk("bp_ready", 32'(acc_ready_w[r]), 32'd0);
        chk("bp_hold", 32'(out_data_w[r]), (r == 0) ? 32'h0000_FF9C : 32'h0);
        chk("bp_cnt", 32'(bias_addr_w[r]), 32'd1);
      end
    end
    out_ready = 1'b1;
    for (int i = 1; i < 15; i++) send(32'(vals_b[i] * 256));
    acc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      chk("bp_drained", 32'(drained[r] - d0[r]), 32'd15);
      chk("bp_class_idx", 32'(class_idx_w[r]), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
